// File: rtl/viterbi_pkg.sv
// Shared Viterbi datapath definitions: one-hot decoder defaults, its state
// type, and the one-hot generator used by onehot_seq_decoder.
package viterbi_pkg;

    localparam int ONEHOT_N_DEFAULT = 11;
    localparam int ONEHOT_N_MAX     = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } onehot_seq_state_t;

    // Widest possible one-hot vector; callers truncate to their own N_OUT.
    // An index at or beyond n yields all zeros.
    function automatic logic [ONEHOT_N_MAX-1:0] f_onehot(input int unsigned idx,
                                                          input int unsigned n);
        logic [ONEHOT_N_MAX-1:0] vec;
        vec = '0;
        if (idx < n && idx < ONEHOT_N_MAX) begin
            vec[idx[5:0]] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/onehot_seq_decoder_if.sv
// Request/response handshake bundle for onehot_seq_decoder.
// slave = decoder side, master = requester/consumer side.
interface onehot_seq_decoder_if
    import viterbi_pkg::*;
#(
    parameter int N_OUT = ONEHOT_N_DEFAULT,
    parameter int IDX_W = $clog2(N_OUT)
) ();

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_sweep;

    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_onehot;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    logic             err_range;

    modport slave (
        input  in_valid, in_idx, in_sweep, out_ready,
        output in_ready, out_valid, out_onehot, out_idx, out_last, err_range
    );

    modport master (
        output in_valid, in_idx, in_sweep, out_ready,
        input  in_ready, out_valid, out_onehot, out_idx, out_last, err_range
    );

endinterface

// File: rtl/onehot_seq_decoder.sv
// Registered, handshaked binary-to-one-hot decoder with optional upward sweep.
// Build option: define ONEHOT_SEQ_WRAP_EN to make sweeps wrap through all N_OUT positions.
module onehot_seq_decoder
    import viterbi_pkg::*;
#(
    parameter int N_OUT = ONEHOT_N_DEFAULT,
    parameter int IDX_W = $clog2(N_OUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    onehot_seq_decoder_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    onehot_seq_state_t state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [N_OUT-1:0]  onehot_reg, onehot_next;
    logic              last_reg, last_next;
    logic              sweep_reg, sweep_next;
    logic              err_reg, err_next;

    logic              out_valid;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;
    logic              in_range;

    logic [IDX_W-1:0]  step_idx;
    logic [N_OUT-1:0]  step_onehot;
    logic              step_last;
    logic [N_OUT-1:0]  load_onehot;
    logic              load_last;

`ifdef ONEHOT_SEQ_WRAP_EN
    logic [IDX_W-1:0]  start_reg, start_next;
    logic [IDX_W-1:0]  end_idx;
`endif

    // Handshake: depends only on registered output state and out_ready.
    assign out_valid = (state_reg == BUSY);
    assign in_ready  = !out_valid || (bus.out_ready && last_reg);
    assign in_fire   = bus.in_valid && in_ready;
    assign out_fire  = out_valid && bus.out_ready;
    assign in_range  = 32'(bus.in_idx) < 32'(N_OUT);

    assign load_onehot = N_OUT'(f_onehot(32'(bus.in_idx), N_OUT));
    assign step_onehot = N_OUT'(f_onehot(32'(step_idx), N_OUT));

`ifdef ONEHOT_SEQ_WRAP_EN
    // A wrapping sweep always covers N_OUT beats, so a fresh sweep is never last.
    assign end_idx   = (start_reg == '0) ? LAST_IDX : start_reg - IDX_W'(1);
    assign step_idx  = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
    assign step_last = (step_idx == end_idx);
    assign load_last = !bus.in_sweep;
`else
    assign step_idx  = idx_reg + IDX_W'(1);
    assign step_last = (step_idx == LAST_IDX);
    assign load_last = !bus.in_sweep || (bus.in_idx == LAST_IDX);
`endif

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        onehot_next = onehot_reg;
        last_next   = last_reg;
        sweep_next  = sweep_reg;
        err_next    = 1'b0;
`ifdef ONEHOT_SEQ_WRAP_EN
        start_next  = start_reg;
`endif

        if (out_fire) begin
            if (last_reg) begin
                state_next  = IDLE;
                onehot_next = '0;
                last_next   = 1'b0;
                sweep_next  = 1'b0;
            end else if (sweep_reg) begin
                idx_next    = step_idx;
                onehot_next = step_onehot;
                last_next   = step_last;
            end
        end

        // A new accept only happens when idle or on the last fire, so it
        // overrides the retire above and loads without a bubble.
        if (in_fire) begin
            if (in_range) begin
                state_next  = BUSY;
                idx_next    = bus.in_idx;
                onehot_next = load_onehot;
                last_next   = load_last;
                sweep_next  = bus.in_sweep;
`ifdef ONEHOT_SEQ_WRAP_EN
                start_next  = bus.in_idx;
`endif
            end else begin
                err_next    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            onehot_reg <= '0;
            last_reg   <= 1'b0;
            sweep_reg  <= 1'b0;
            err_reg    <= 1'b0;
`ifdef ONEHOT_SEQ_WRAP_EN
            start_reg  <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            onehot_reg <= onehot_next;
            last_reg   <= last_next;
            sweep_reg  <= sweep_next;
            err_reg    <= err_next;
`ifdef ONEHOT_SEQ_WRAP_EN
            start_reg  <= start_next;
`endif
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_onehot = onehot_reg;
    assign bus.out_idx    = idx_reg;
    assign bus.out_last   = last_reg;
    assign bus.err_range  = err_reg;

endmodule
